// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int unsigned DefaultN = 8;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic C
);

    assign S = A ^ B ^ CIN;
    assign C = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, result published after N RUN edges.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] S,
    output logic         COUT
);

    localparam int unsigned CW = $clog2(N);

    logic [0:0]   state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0] a_sh_q;
    logic [N-1:0] b_sh_q;
    logic [N-1:0] r_sh_q;
    logic         carry_q;
    logic [N-1:0] s_q;
    logic         cout_q;
    logic         done_q;

    logic         cell_s;
    logic         cell_c;
    logic [N-1:0] r_next;

    fa_cell u_fa_cell (
        .A   (a_sh_q[0]),
        .B   (b_sh_q[0]),
        .CIN (carry_q),
        .S   (cell_s),
        .C   (cell_c)
    );

    // Sum bits enter at the MSB so that after N shifts bit 0 sits at the LSB.
    assign r_next = {cell_s, r_sh_q[N-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        a_sh_q  <= A;
                        b_sh_q  <= B;
                        carry_q <= CIN;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    r_sh_q  <= r_next;
                    carry_q <= cell_c;
                    // Counter holds at terminal count rather than wrapping.
                    if (cnt_q == CW'(N - 1)) begin
                        s_q     <= r_next;
                        cout_q  <= cell_c;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY = (state_q == StRun);
    assign DONE = done_q;
    assign S    = s_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: N=8 directed cases and an N=4 exhaustive back-to-back sweep.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic       rst4, start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, s4;

    serial_adder #(.N(8)) u_dut8 (
        .CLK(clk), .RST(rst8), .START(start8), .A(a8), .B(b8), .CIN(cin8),
        .BUSY(busy8), .DONE(done8), .S(s8), .COUT(cout8)
    );

    serial_adder #(.N(4)) u_dut4 (
        .CLK(clk), .RST(rst4), .START(start4), .A(a4), .B(b4), .CIN(cin4),
        .BUSY(busy4), .DONE(done4), .S(s4), .COUT(cout4)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;
    int cyc = 0;
    int last_done4 = -1;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [8:0] e8;
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(1), 64'(0));
            end else begin
                e8 = q8.pop_front();
                check("sum8", 64'({cout8, s8}), 64'(e8));
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e4;
        if (done4) begin
            done_cnt4++;
            if (q4.size() == 0) begin
                check("unexpected_done4", 64'(1), 64'(0));
            end else begin
                e4 = q4.pop_front();
                check("sum4", 64'({cout4, s4}), 64'(e4));
            end
            if (last_done4 >= 0) check("done4_period", 64'(cyc - last_done4), 64'(5));
            last_done4 = cyc;
        end
    end

    // mode 0: plain op, 1: START/operand noise while busy, 2: reset at RUN cycle 4.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int mode);
        int k;
        int busy_n;
        int cnt0;
        logic [7:0] s_hold;
        logic s_moved;
        cnt0    = done_cnt8;
        s_hold  = s8;
        s_moved = 1'b0;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        k = 0;
        busy_n = 0;
        while (!done8 && k < 24) begin
            busy_n += int'(busy8);
            if (s8 !== s_hold) s_moved = 1'b1;
            if (mode == 1 && k == 3) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
            end else if (mode == 1 && k == 4) begin
                start8 = 1'b0; a8 = 8'hA5; b8 = 8'h11; cin8 = 1'b1;
            end
            if (mode == 2 && k == 4) begin
                rst8 = 1'b1;
                @(negedge clk);
                rst8 = 1'b0;
                q8.delete();
                check("rst_busy", 64'(busy8), 64'(0));
                check("rst_s", 64'(s8), 64'(0));
                check("rst_cout", 64'(cout8), 64'(0));
                check("rst_done", 64'(done8), 64'(0));
                break;
            end
            @(negedge clk);
            k++;
        end
        if (mode == 2) begin
            repeat (12) @(negedge clk);
            check("no_done_after_rst", 64'(done_cnt8 - cnt0), 64'(0));
        end else begin
            check("latency", 64'(k), 64'(8));
            check("busy_cycles", 64'(busy_n), 64'(8));
            check("busy_at_done", 64'(busy8), 64'(0));
            check("s_stable_run", 64'(s_moved), 64'(0));
            @(negedge clk);
            check("done_pulse", 64'(done8), 64'(0));
            check("done_count", 64'(done_cnt8 - cnt0), 64'(1));
            check("idle_after", 64'(busy8), 64'(0));
        end
    endtask

    initial begin
        int idx;
        int guard;
        logic [8:0] v;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy8), 64'(0));
        check("reset_done", 64'(done8), 64'(0));
        check("reset_s", 64'(s8), 64'(0));
        check("reset_cout", 64'(cout8), 64'(0));
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        do_op(8'h5A, 8'h3C, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        do_op(8'h5A, 8'h3C, 1'b0, 1);
        do_op(8'h5A, 8'h3C, 1'b0, 2);
        do_op(8'h01, 8'h01, 1'b1, 0);
        check("final_s8", 64'(s8), 64'(8'h03));

        // N=4 sweep with START held high: a new operand set is accepted in every DONE cycle.
        idx = 0;
        guard = 0;
        start4 = 1'b1;
        while (idx < 512 && guard < 4000) begin
            if (!busy4) begin
                v = 9'(idx);
                a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
                q4.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        start4 = 1'b0;
        guard = 0;
        while (q4.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("sweep_issued", 64'(idx), 64'(512));
        check("q4_drained", 64'(q4.size()), 64'(0));
        check("done4_count", 64'(done_cnt4), 64'(512));
        check("q8_drained", 64'(q8.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, default 8, operand width in bits, legal range 2..32.
REQ-002 Port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port RST  input  1  reset; synchronous, active-high.
REQ-004 Port START  input  1  request to begin an addition; sampled only when BUSY=0.
REQ-005 Port A  input  N  addend operand, captured on the accepting edge.
REQ-006 Port B  input  N  addend operand, captured on the accepting edge.
REQ-007 Port CIN  input  1  carry-in, captured on the accepting edge.
REQ-008 Port BUSY  output  1  high while an addition is in progress.
REQ-009 Port DONE  output  1  single-cycle pulse marking result valid.
REQ-010 Port S  output  N  sum result, registered.
REQ-011 Port COUT  output  1  carry-out result, registered.

Function
REQ-012 The block SHALL compute {COUT,S} = A + B + CIN, one bit per clock, LSB first, through a single 1-bit full-adder cell with a registered carry.
REQ-013 FSM states SHALL be IDLE and RUN; IDLE->RUN on an edge with START=1 and BUSY=0; RUN->IDLE on the edge that processes bit N-1.
REQ-014 The accepting edge SHALL load A and B into shift registers, load CIN into the carry flop, clear the bit counter, and set BUSY=1.
REQ-015 Each RUN edge SHALL shift both operands right by one, shift the cell sum into the MSB of a result shift register, update the carry flop from the cell carry, and increment the counter.
REQ-016 The counter SHALL be ceil(log2(N)) bits wide and SHALL not wrap within one operation; terminal count is N-1.
REQ-017 On the terminal RUN edge, S SHALL take the full N-bit result, COUT the final carry, BUSY SHALL fall, and DONE SHALL rise. Latency is exactly N edges from the accepting edge to DONE=1.
REQ-018 DONE SHALL be high for exactly one cycle. S and COUT SHALL hold their values until the next terminal edge or reset.
REQ-019 S and COUT SHALL NOT change during RUN. Intermediate bits live only in internal shift registers.
REQ-020 START while BUSY=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 START in the DONE cycle (BUSY=0) SHALL be accepted. Back-to-back operations SHALL give a throughput of one result per N+1 cycles.
REQ-022 Changes on A, B or CIN after the accepting edge SHALL have no effect on the result.

Reset
REQ-023 With RST=1 at an edge: state=IDLE, BUSY=0, DONE=0, S=0, COUT=0, carry flop=0, counter=0, and all shift registers=0.
REQ-024 RST SHALL take priority over START and over an in-flight RUN. A reset mid-operation aborts it, and no DONE pulse is produced.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1) and the default width constant N=8.
REQ-026 The 1-bit full-adder cell SHALL be a separate sub-module named fa_cell (ports S, C, A, B, CIN; purely combinational), instantiated once.
REQ-027 All other logic, including the FSM, counter, shift registers and carry flop, SHALL reside in serial_adder.

Verification (N=8)
REQ-028 Basic: A=0x5A, B=0x3C, CIN=0, START pulse -> BUSY high 8 cycles, then DONE for 1 cycle with S=0x96, COUT=0.
REQ-029 Carry ripple: A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1. Also A=0xFF, B=0xFF, CIN=1 -> S=0xFF, COUT=1.
REQ-030 Exhaustive: N=4 instance, all 512 (A,B,CIN) combinations run back-to-back with START held high -> each {COUT,S} matches the reference sum, with a DONE every 5 cycles.
REQ-031 Busy protection: during a 0x5A+0x3C run, pulse START with A=0x00, B=0x00 at cycle 3 and change the A and B inputs -> result is still 0x96, COUT=0, and only one DONE.
REQ-032 Mid-op reset: assert RST for one cycle at RUN cycle 4 -> next cycle BUSY=0, S=0, COUT=0, no DONE. A following 0x01+0x01+1 -> S=0x03.
